// File: rtl/lane_scheduler.sv
// Frogger car-lane sequencer: rotates one 16-bit car pattern per lane from a shared
// prescaler, detects frog collisions and freezes the field. Optional macro: HIT_FLASH_EN.
module lane_scheduler #(
  parameter int NLANES  = 4,
  parameter int PRESC_W = 10,
  parameter int SEL_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              frog_valid,
  input  logic [SEL_W-1:0]  frog_row,
  input  logic [3:0]        frog_col,
  input  logic [SEL_W-1:0]  row_sel,
  output logic [15:0]       pixels,
  output logic              hit,
  output logic              running,
  output logic [NLANES-1:0] step
);

  localparam logic [15:0] BASE_PAT = 16'hDB6D;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  function automatic logic [15:0] init_pat(input int lane);
    logic [15:0] p;
    p = BASE_PAT;
    for (int k = 0; k < 8; k++)
      if (k < lane) p = {p[14:0], p[15]};
    return p;
  endfunction

  function automatic logic [15:0] rotate(input logic [15:0] p, input logic odd);
    return odd ? {p[14:0], p[15]} : {p[0], p[15:1]};
  endfunction

  state_t              state, state_nxt;
  logic [15:0]         pat [NLANES];
  logic [2:0]          div [NLANES];
  logic [PRESC_W-1:0]  presc;
  logic                presc_en, tick, collide, enter_run, row_ok;
  logic [NLANES-1:0]   fire;
  logic [15:0]         sel_pat, pix_nxt;
`ifdef HIT_FLASH_EN
  logic                flash_ph;
`endif

  // Lane lookups are decoded by loop so out-of-range indices simply match nothing.
  always_comb begin
    collide = 1'b0;
    row_ok  = 1'b0;
    sel_pat = 16'h0000;
    for (int i = 0; i < NLANES; i++) begin
      if (frog_valid && frog_row == SEL_W'(i)) collide = pat[i][frog_col];
      if (row_sel == SEL_W'(i)) begin
        row_ok  = 1'b1;
        sel_pat = pat[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = RUN;
      RUN:     if (collide) state_nxt = OVER;
      OVER:    if (start)   state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    enter_run = (state_nxt == RUN) && (state != RUN);
`ifdef HIT_FLASH_EN
    presc_en = (state == RUN) || (state == OVER);
`else
    presc_en = (state == RUN);
`endif
    tick = presc_en && (&presc);
    // A collision in a tick cycle suppresses the rotation: the pre-rotation field decides.
    for (int i = 0; i < NLANES; i++)
      fire[i] = (state == RUN) && tick && !collide && (div[i] == 3'(i));
  end

  always_comb begin
    pix_nxt = 16'h0000;
    if (state != OVER) begin
      pix_nxt = row_ok ? sel_pat : 16'h0000;
    end else begin
`ifdef HIT_FLASH_EN
      pix_nxt = (row_ok && flash_ph) ? 16'hFFFF : 16'h0000;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      presc   <= '0;
      pixels  <= 16'h0000;
      hit     <= 1'b0;
      running <= 1'b0;
      step    <= '0;
      for (int i = 0; i < NLANES; i++) begin
        pat[i] <= init_pat(i);
        div[i] <= 3'd0;
      end
`ifdef HIT_FLASH_EN
      flash_ph <= 1'b1;
`endif
    end else begin
      state   <= state_nxt;
      hit     <= (state_nxt == OVER);
      running <= (state_nxt == RUN);
      step    <= fire;
      pixels  <= pix_nxt;
      if (enter_run)     presc <= '0;
      else if (presc_en) presc <= presc + 1'b1;
      else               presc <= '0;
      for (int i = 0; i < NLANES; i++) begin
        if (enter_run) begin
          pat[i] <= init_pat(i);
          div[i] <= 3'd0;
        end else begin
          if (fire[i]) pat[i] <= rotate(pat[i], i[0]);
          if ((state == RUN) && tick && !collide)
            div[i] <= (div[i] == 3'(i)) ? 3'd0 : div[i] + 3'd1;
        end
      end
`ifdef HIT_FLASH_EN
      if (state_nxt == OVER && state != OVER) flash_ph <= 1'b1;
      else if (state == OVER && tick)         flash_ph <= ~flash_ph;
`endif
    end
  end

endmodule
